// File: rtl/pte_ad_writer_pkg.sv
// Purpose : shared PTE layout constants, writer FSM state encoding and the PTE packing helper.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package pte_ad_writer_pkg;

  localparam int PTE_W   = 64;
  localparam int PPN_W   = 54;
  localparam int PPN_LSB = 10;
  localparam int RSW_W   = 2;
  localparam int RSW_LSB = 8;
  localparam int FLAG_W  = 8;

  // Flag bit positions inside the low byte of the PTE word.
  localparam int BIT_V = 0;
  localparam int BIT_R = 1;
  localparam int BIT_W = 2;
  localparam int BIT_X = 3;
  localparam int BIT_U = 4;
  localparam int BIT_G = 5;
  localparam int BIT_A = 6;
  localparam int BIT_D = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } state_t;

  // Flags are given as {d, a, g, u, x, w, r, v}; RSW bits are always written as zero.
  function automatic logic [PTE_W-1:0] pte_pack(input logic [PPN_W-1:0]  ppn,
                                                input logic [FLAG_W-1:0] flags);
    logic [PTE_W-1:0] word;
    word                       = '0;
    word[PPN_LSB +: PPN_W]     = ppn;
    word[RSW_LSB +: RSW_W]     = '0;
    word[FLAG_W-1:0]           = flags;
    return word;
  endfunction

endpackage

// File: rtl/pte_ad_writer_pack_unit.sv
// Purpose : combinational unpacked PTE fields -> 64-bit Sv39/Sv48 PTE word.
// Latency : combinational, zero cycles.
// Backpressure : none; pure function of its inputs.
// Ports : ppn, d..v in (unpacked PTE), word out (packed entry).
module pte_pack_unit
  import pte_ad_writer_pkg::*;
(
  input  logic [PPN_W-1:0] ppn,
  input  logic             d,
  input  logic             a,
  input  logic             g,
  input  logic             u,
  input  logic             x,
  input  logic             w,
  input  logic             r,
  input  logic             v,
  output logic [PTE_W-1:0] word
);

  assign word = pte_pack(ppn, {d, a, g, u, x, w, r, v});

endmodule

// File: rtl/pte_ad_writer.sv
// Purpose : sets A/D on a PTE, writes the packed entry back with one store, returns the updated PTE.
// Latency : skip/illegal -> response the cycle after request; store -> response the cycle after the ack.
// Backpressure : one request in flight; req_ready low outside IDLE, store and response held until accepted.
// Ports : io_req_* (walker request), io_mem_req_* / io_mem_resp_valid (store port), io_resp_* (walker response).
module pte_ad_writer
  import pte_ad_writer_pkg::*;
#(
  parameter int PADDR_BITS     = 56,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  io_req_ready,
  input  logic                  io_req_valid,
  input  logic [PADDR_BITS-1:0] io_req_bits_addr,
  input  logic                  io_req_bits_set_d,
  input  logic [PPN_W-1:0]      io_req_bits_pte_ppn,
  input  logic                  io_req_bits_pte_d,
  input  logic                  io_req_bits_pte_a,
  input  logic                  io_req_bits_pte_g,
  input  logic                  io_req_bits_pte_u,
  input  logic                  io_req_bits_pte_x,
  input  logic                  io_req_bits_pte_w,
  input  logic                  io_req_bits_pte_r,
  input  logic                  io_req_bits_pte_v,
  input  logic                  io_mem_req_ready,
  output logic                  io_mem_req_valid,
  output logic [PADDR_BITS-1:0] io_mem_req_bits_addr,
  output logic [PTE_W-1:0]      io_mem_req_bits_data,
  input  logic                  io_mem_resp_valid,
  input  logic                  io_resp_ready,
  output logic                  io_resp_valid,
  output logic [PPN_W-1:0]      io_resp_bits_pte_ppn,
  output logic                  io_resp_bits_pte_d,
  output logic                  io_resp_bits_pte_a,
  output logic                  io_resp_bits_pte_g,
  output logic                  io_resp_bits_pte_u,
  output logic                  io_resp_bits_pte_x,
  output logic                  io_resp_bits_pte_w,
  output logic                  io_resp_bits_pte_r,
  output logic                  io_resp_bits_pte_v,
  output logic                  io_resp_bits_skipped,
  output logic                  io_resp_bits_error
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic                    req_ready_q;
  logic                    mreq_vld_q;
  logic                    resp_vld_q;
  logic [PADDR_BITS-1:0]   addr_q;
  logic [PPN_W-1:0]        ppn_q;
  logic [FLAG_W-1:0]       flags_q;
  logic                    skipped_q;
  logic                    error_q;
  logic                    drain_pend;
  logic [CNT_W-1:0]        cnt;

  logic [FLAG_W-1:0]       req_flags;
  logic [FLAG_W-1:0]       new_flags;
  logic                    illegal;

  assign req_flags = {io_req_bits_pte_d, io_req_bits_pte_a, io_req_bits_pte_g, io_req_bits_pte_u,
                      io_req_bits_pte_x, io_req_bits_pte_w, io_req_bits_pte_r, io_req_bits_pte_v};

  // A is always set; D only for store accesses.
  always_comb begin
    new_flags        = req_flags;
    new_flags[BIT_A] = 1'b1;
    new_flags[BIT_D] = req_flags[BIT_D] | io_req_bits_set_d;
  end

  // Invalid, non-leaf, or a dirty-set on a non-writable page.
  assign illegal = !req_flags[BIT_V]
                 || !(req_flags[BIT_R] || req_flags[BIT_W] || req_flags[BIT_X])
                 || (io_req_bits_set_d && !req_flags[BIT_W]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      req_ready_q <= 1'b1;
      mreq_vld_q  <= 1'b0;
      resp_vld_q  <= 1'b0;
      addr_q      <= '0;
      ppn_q       <= '0;
      flags_q     <= '0;
      skipped_q   <= 1'b0;
      error_q     <= 1'b0;
      drain_pend  <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_req_valid) begin
            addr_q      <= io_req_bits_addr;
            ppn_q       <= io_req_bits_pte_ppn;
            req_ready_q <= 1'b0;
            drain_pend  <= 1'b0;
            skipped_q   <= 1'b0;
            error_q     <= 1'b0;
            if (illegal) begin
              flags_q    <= req_flags;
              error_q    <= 1'b1;
              resp_vld_q <= 1'b1;
              state      <= ST_RESP;
            end else if (new_flags == req_flags) begin
              flags_q    <= new_flags;
              skipped_q  <= 1'b1;
              resp_vld_q <= 1'b1;
              state      <= ST_RESP;
            end else begin
              flags_q    <= new_flags;
              mreq_vld_q <= 1'b1;
              state      <= ST_STORE;
            end
          end
        end
        ST_STORE: begin
          if (io_mem_req_ready) begin
            mreq_vld_q <= 1'b0;
            cnt        <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Ack wins over a timeout in the same cycle.
          if (io_mem_resp_valid) begin
            resp_vld_q <= 1'b1;
            state      <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            error_q    <= 1'b1;
            drain_pend <= 1'b1;
            resp_vld_q <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          // A late ack can land while the error response is still stalled;
          // consume it here so DRAIN does not wait for a second one.
          if (drain_pend && io_mem_resp_valid) drain_pend <= 1'b0;
          if (io_resp_ready) begin
            resp_vld_q <= 1'b0;
            if (drain_pend && !io_mem_resp_valid) begin
              state <= ST_DRAIN;
            end else begin
              state       <= ST_IDLE;
              req_ready_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (io_mem_resp_valid) begin
            drain_pend  <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  pte_pack_unit u_pack (
    .ppn  (ppn_q),
    .d    (flags_q[BIT_D]),
    .a    (flags_q[BIT_A]),
    .g    (flags_q[BIT_G]),
    .u    (flags_q[BIT_U]),
    .x    (flags_q[BIT_X]),
    .w    (flags_q[BIT_W]),
    .r    (flags_q[BIT_R]),
    .v    (flags_q[BIT_V]),
    .word (io_mem_req_bits_data)
  );

  assign io_req_ready         = req_ready_q;
  assign io_mem_req_valid     = mreq_vld_q;
  assign io_mem_req_bits_addr = addr_q;
  assign io_resp_valid        = resp_vld_q;
  assign io_resp_bits_pte_ppn = ppn_q;
  assign io_resp_bits_pte_d   = flags_q[BIT_D];
  assign io_resp_bits_pte_a   = flags_q[BIT_A];
  assign io_resp_bits_pte_g   = flags_q[BIT_G];
  assign io_resp_bits_pte_u   = flags_q[BIT_U];
  assign io_resp_bits_pte_x   = flags_q[BIT_X];
  assign io_resp_bits_pte_w   = flags_q[BIT_W];
  assign io_resp_bits_pte_r   = flags_q[BIT_R];
  assign io_resp_bits_pte_v   = flags_q[BIT_V];
  assign io_resp_bits_skipped = skipped_q;
  assign io_resp_bits_error   = error_q;

endmodule

// File: tb/tb_pte_ad_writer.sv
// Purpose : self-checking bench for pte_ad_writer with directed and randomized transactions.
// Latency : n/a (testbench).
// Backpressure : randomized ready/ack timing on the store port and the walker response.
module tb_pte_ad_writer;

  localparam int PA = 56;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_req_ready, io_req_valid, io_req_bits_set_d;
  logic [PA-1:0] io_req_bits_addr;
  logic [53:0]   io_req_bits_pte_ppn;
  logic          io_req_bits_pte_d, io_req_bits_pte_a, io_req_bits_pte_g, io_req_bits_pte_u;
  logic          io_req_bits_pte_x, io_req_bits_pte_w, io_req_bits_pte_r, io_req_bits_pte_v;
  logic          io_mem_req_ready, io_mem_req_valid, io_mem_resp_valid;
  logic [PA-1:0] io_mem_req_bits_addr;
  logic [63:0]   io_mem_req_bits_data;
  logic          io_resp_ready, io_resp_valid;
  logic [53:0]   io_resp_bits_pte_ppn;
  logic          io_resp_bits_pte_d, io_resp_bits_pte_a, io_resp_bits_pte_g, io_resp_bits_pte_u;
  logic          io_resp_bits_pte_x, io_resp_bits_pte_w, io_resp_bits_pte_r, io_resp_bits_pte_v;
  logic          io_resp_bits_skipped, io_resp_bits_error;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] last_store_data;

  always #5 clock = ~clock;

  pte_ad_writer #(.PADDR_BITS(PA), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .io_req_ready(io_req_ready), .io_req_valid(io_req_valid),
    .io_req_bits_addr(io_req_bits_addr), .io_req_bits_set_d(io_req_bits_set_d),
    .io_req_bits_pte_ppn(io_req_bits_pte_ppn),
    .io_req_bits_pte_d(io_req_bits_pte_d), .io_req_bits_pte_a(io_req_bits_pte_a),
    .io_req_bits_pte_g(io_req_bits_pte_g), .io_req_bits_pte_u(io_req_bits_pte_u),
    .io_req_bits_pte_x(io_req_bits_pte_x), .io_req_bits_pte_w(io_req_bits_pte_w),
    .io_req_bits_pte_r(io_req_bits_pte_r), .io_req_bits_pte_v(io_req_bits_pte_v),
    .io_mem_req_ready(io_mem_req_ready), .io_mem_req_valid(io_mem_req_valid),
    .io_mem_req_bits_addr(io_mem_req_bits_addr), .io_mem_req_bits_data(io_mem_req_bits_data),
    .io_mem_resp_valid(io_mem_resp_valid),
    .io_resp_ready(io_resp_ready), .io_resp_valid(io_resp_valid),
    .io_resp_bits_pte_ppn(io_resp_bits_pte_ppn),
    .io_resp_bits_pte_d(io_resp_bits_pte_d), .io_resp_bits_pte_a(io_resp_bits_pte_a),
    .io_resp_bits_pte_g(io_resp_bits_pte_g), .io_resp_bits_pte_u(io_resp_bits_pte_u),
    .io_resp_bits_pte_x(io_resp_bits_pte_x), .io_resp_bits_pte_w(io_resp_bits_pte_w),
    .io_resp_bits_pte_r(io_resp_bits_pte_r), .io_resp_bits_pte_v(io_resp_bits_pte_v),
    .io_resp_bits_skipped(io_resp_bits_skipped), .io_resp_bits_error(io_resp_bits_error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] resp_flags();
    return {io_resp_bits_pte_d, io_resp_bits_pte_a, io_resp_bits_pte_g, io_resp_bits_pte_u,
            io_resp_bits_pte_x, io_resp_bits_pte_w, io_resp_bits_pte_r, io_resp_bits_pte_v};
  endfunction

  task automatic check_idle_reset_values(input string tag);
    chk({tag, "_req_ready"}, 64'(io_req_ready), 64'd1);
    chk({tag, "_mem_req_valid"}, 64'(io_mem_req_valid), 64'd0);
    chk({tag, "_resp_valid"}, 64'(io_resp_valid), 64'd0);
    chk({tag, "_mem_addr"}, 64'(io_mem_req_bits_addr), 64'd0);
    chk({tag, "_mem_data"}, io_mem_req_bits_data, 64'd0);
    chk({tag, "_resp_pte"}, {2'b0, io_resp_bits_pte_ppn, resp_flags()}, 64'd0);
    chk({tag, "_resp_sk_er"}, {62'd0, io_resp_bits_skipped, io_resp_bits_error}, 64'd0);
  endtask

  task automatic drive_req(input logic [PA-1:0] addr, input logic [53:0] ppn,
                           input logic [7:0] fl, input logic sd);
    io_req_valid        = 1'b1;
    io_req_bits_addr    = addr;
    io_req_bits_pte_ppn = ppn;
    io_req_bits_set_d   = sd;
    {io_req_bits_pte_d, io_req_bits_pte_a, io_req_bits_pte_g, io_req_bits_pte_u,
     io_req_bits_pte_x, io_req_bits_pte_w, io_req_bits_pte_r, io_req_bits_pte_v} = fl;
  endtask

  // One complete transaction; expectations come from the A/D rules, not from the DUT.
  task automatic run_txn(input string tag, input logic [PA-1:0] addr, input logic [53:0] ppn,
                         input logic [7:0] fl, input logic sd, input int rdy_dly,
                         input int ack_dly, input int rsp_dly, input bit to);
    logic        legal, skip, store, done, bad_store, unstable, busy_rdy, saw_mreq;
    logic [7:0]  nf, exp_fl, r_fl;
    logic [63:0] exp_word;
    logic [53:0] r_ppn;
    logic        r_sk, r_er;
    int          acc_k, ack_k, rv_k, stores, k, drain_busy;

    legal    = fl[0] && (fl[1] || fl[2] || fl[3]) && !(sd && !fl[2]);
    nf       = fl | 8'h40 | (sd ? 8'h80 : 8'h00);
    skip     = legal && (nf == fl);
    store    = legal && !skip;
    exp_fl   = legal ? nf : fl;
    exp_word = 64'(ppn) * 64'd1024 + 64'(nf);

    done = 0; bad_store = 0; unstable = 0; busy_rdy = 0; saw_mreq = 0;
    acc_k = -1; ack_k = -1; rv_k = -1; stores = 0; drain_busy = 0;
    r_fl = '0; r_ppn = '0; r_sk = 0; r_er = 0;

    @(negedge clock);
    chk({tag, "_req_ready"}, 64'(io_req_ready), 64'd1);
    drive_req(addr, ppn, fl, sd);
    io_mem_resp_valid = 1'b0;
    io_resp_ready     = 1'b0;
    @(posedge clock);

    for (k = 1; k <= 100 && !done; k++) begin
      @(negedge clock);
      io_req_valid      = 1'b0;
      io_mem_resp_valid = 1'b0;
      if (io_req_ready) busy_rdy = 1;
      if (io_mem_req_valid) begin
        saw_mreq = 1;
        if (io_mem_req_bits_addr !== addr || io_mem_req_bits_data !== exp_word) bad_store = 1;
        io_mem_req_ready = (k > rdy_dly);
        if (io_mem_req_ready) begin
          stores++;
          acc_k = k;
          last_store_data = io_mem_req_bits_data;
        end
      end else begin
        io_mem_req_ready = 1'($urandom_range(0, 1));
      end
      if (acc_k > 0 && !to && k == acc_k + ack_dly) begin
        io_mem_resp_valid = 1'b1;
        ack_k = k;
      end
      if (io_resp_valid) begin
        if (rv_k < 0) begin
          rv_k  = k;
          r_fl  = resp_flags();
          r_ppn = io_resp_bits_pte_ppn;
          r_sk  = io_resp_bits_skipped;
          r_er  = io_resp_bits_error;
        end else if (resp_flags() !== r_fl || io_resp_bits_pte_ppn !== r_ppn ||
                     io_resp_bits_skipped !== r_sk || io_resp_bits_error !== r_er) begin
          unstable = 1;
        end
        io_resp_ready = (k >= rv_k + rsp_dly);
        if (io_resp_ready) done = 1;
      end else begin
        io_resp_ready = 1'($urandom_range(0, 1));
      end
    end

    chk({tag, "_resp_done"}, 64'(done), 64'd1);
    chk({tag, "_stores"}, 64'(stores), (store || to) ? 64'd1 : 64'd0);
    if (!store && !to) chk({tag, "_no_mem_req"}, 64'(saw_mreq), 64'd0);
    if (store || to) chk({tag, "_store_payload"}, 64'(bad_store), 64'd0);
    chk({tag, "_busy_ready"}, 64'(busy_rdy), 64'd0);
    chk({tag, "_resp_stable"}, 64'(unstable), 64'd0);
    chk({tag, "_resp_ppn"}, 64'(r_ppn), 64'(ppn));
    chk({tag, "_resp_error"}, 64'(r_er), (!legal || to) ? 64'd1 : 64'd0);
    chk({tag, "_resp_skipped"}, 64'(r_sk), (skip && !to) ? 64'd1 : 64'd0);
    if (!to) chk({tag, "_resp_flags"}, 64'(r_fl), 64'(exp_fl));
    if (!store && !to) chk({tag, "_latency"}, 64'(rv_k), 64'd1);
    else if (!to) chk({tag, "_latency"}, 64'(rv_k), 64'(ack_k + 1));
    else chk({tag, "_timeout_at"}, 64'(rv_k), 64'(acc_k + TO + 1));

    if (to) begin
      // Late acknowledge: ready must stay low until it arrives.
      for (int j = 0; j < 19; j++) begin
        @(negedge clock);
        io_resp_ready = 1'b0;
        if (io_req_ready) drain_busy = 1;
      end
      @(negedge clock);
      if (io_req_ready) drain_busy = 1;
      io_mem_resp_valid = 1'b1;
      @(negedge clock);
      io_mem_resp_valid = 1'b0;
      chk({tag, "_drain_busy"}, 64'(drain_busy), 64'd0);
      chk({tag, "_drain_release"}, 64'(io_req_ready), 64'd1);
    end
    @(negedge clock);
    io_mem_resp_valid = 1'b0;
    io_resp_ready     = 1'b0;
  endtask

  initial begin
    logic [PA-1:0] a;
    logic [53:0]   p;
    logic [7:0]    f;
    reset = 1'b1;
    io_req_valid = 1'b0; io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0; io_resp_ready = 1'b0;
    drive_req('0, '0, 8'h00, 1'b0);
    io_req_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle_reset_values("reset");

    run_txn("basic", 56'h80001000, 54'h12345, 8'h07, 1'b1, 0, 3, 0, 0);
    chk("basic_word", last_store_data, 64'h48D14C7);
    run_txn("skip", 56'h80001000, 54'h12345, 8'hC7, 1'b1, 0, 3, 0, 0);
    run_txn("ill_v0", 56'h80002000, 54'h12345, 8'h06, 1'b0, 0, 1, 0, 0);
    run_txn("ill_nonleaf", 56'h80003000, 54'h12345, 8'h01, 1'b0, 0, 1, 0, 0);
    run_txn("ill_ro_dirty", 56'h80004000, 54'h12345, 8'h03, 1'b1, 0, 1, 0, 0);
    run_txn("stall", 56'h80005000, 54'h2ABCD, 8'h0B, 1'b0, 5, 2, 4, 0);
    run_txn("ack_at_limit", 56'h80006000, 54'h00777, 8'h07, 1'b1, 0, TO, 0, 0);
    run_txn("timeout", 56'h80007000, 54'h01234, 8'h07, 1'b1, 0, 1, 0, 1);

    // Reset while waiting for an ack, then a stray ack in IDLE.
    @(negedge clock);
    drive_req(56'h80008000, 54'h5555, 8'h07, 1'b1);
    @(negedge clock);
    io_req_valid = 1'b0;
    io_mem_req_ready = 1'b1;
    @(negedge clock);
    io_mem_req_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle_reset_values("midreset");
    io_mem_resp_valid = 1'b1;
    @(negedge clock);
    io_mem_resp_valid = 1'b0;
    chk("stray_ack_resp_valid", 64'(io_resp_valid), 64'd0);
    chk("stray_ack_req_ready", 64'(io_req_ready), 64'd1);
    run_txn("after_reset", 56'h80009000, 54'h3C3C3, 8'h0F, 1'b1, 1, 2, 1, 0);

    for (int i = 0; i < 40; i++) begin
      a = PA'({$urandom, $urandom}) & ~PA'(7);
      p = 54'({$urandom, $urandom});
      f = 8'($urandom);
      if ($urandom_range(0, 3) != 0) f[0] = 1'b1;
      run_txn($sformatf("rnd%0d", i), a, p, f, 1'($urandom_range(0, 1)),
              $urandom_range(0, 4), $urandom_range(1, TO), $urandom_range(0, 3), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pte_ad_writer.md
Name: pte_ad_writer

Overview:
- Writer side of the page-table-entry path: takes an unpacked PTE (ppn, d, a, g, u, x, w, r, v) plus its physical address and an A/D-update command.
- Sets the Accessed/Dirty bits, packs the entry into a 64-bit Sv39/Sv48 PTE word and issues one full-width memory store.
- Returns the updated unpacked PTE to the page-table walker.
- Sits between the PTW and the memory-side store port; it is the write-back counterpart of PTE fetch and unpacking.

Parameters:
- PADDR_BITS, 56, physical address width of the PTE location
- TIMEOUT_CYCLES, 1024, maximum cycles from store issue to store acknowledge before an error response (must be ≥ 2)

Ports:
- clock  input  1  sole clock
- reset  input  1  synchronous, active-high reset
- io_req_ready  output  1  block can accept a request
- io_req_valid  input  1  request present
- io_req_bits_addr  input  PADDR_BITS  PTE physical address, 8-byte aligned
- io_req_bits_set_d  input  1  also set D (store access); A is always set
- io_req_bits_pte_ppn  input  54  current PTE ppn
- io_req_bits_pte_{d,a,g,u,x,w,r,v}  input  1 each  current PTE flags
- io_mem_req_ready  input  1  store port accepts
- io_mem_req_valid  output  1  store request
- io_mem_req_bits_addr  output  PADDR_BITS  store address
- io_mem_req_bits_data  output  64  packed PTE word
- io_mem_resp_valid  input  1  store acknowledge, single-cycle pulse, always accepted
- io_resp_ready  input  1  walker accepts response
- io_resp_valid  output  1  response present
- io_resp_bits_pte_ppn  output  54  updated ppn (unchanged)
- io_resp_bits_pte_{d,a,g,u,x,w,r,v}  output  1 each  updated flags
- io_resp_bits_skipped  output  1  no store was needed
- io_resp_bits_error  output  1  illegal request or timeout

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset:
  - State returns to IDLE.
  - All valids are 0; io_req_ready is 1 on the first cycle after reset deasserts.
  - Registered payload outputs are 0.
  - The timeout counter is 0.
- Reset mid-operation aborts silently. A later stray io_mem_resp_valid in IDLE is ignored.
- States: IDLE, STORE, WAIT, RESP, DRAIN.
- IDLE:
  - io_req_ready = 1.
  - On a request fire, capture addr and the PTE, then compute new_a = 1 and new_d = d | set_d.
  - Illegal when v = 0, or r = w = x = 0 (non-leaf), or set_d = 1 with w = 0. An illegal request goes to RESP with error = 1, no store, and the PTE returned unchanged.
  - If new_a == a and new_d == d, go to RESP with skipped = 1 and no store.
  - Otherwise go to STORE.
- Packing:
  - data[63:10] = ppn; data[9:8] = 0 (RSW);
  - data[7:0] = {d, a, g, u, x, w, r, v}, using the updated flags.
- STORE: io_mem_req_valid = 1 with stable addr/data. On io_mem_req_ready go to WAIT; clear the counter.
- WAIT:
  - The counter increments each cycle.
  - io_mem_resp_valid → RESP with error = 0 and the updated PTE.
  - If the counter reaches TIMEOUT_CYCLES−1 without an acknowledge → RESP with error = 1 and a DRAIN-pending flag set.
  - An acknowledge in the same cycle as the timeout counts as success.
- RESP:
  - io_resp_valid held until io_resp_ready. Payload stays stable while stalled.
  - On fire: go to DRAIN if the DRAIN-pending flag is set, else IDLE.
  - Latency from request fire: skip or illegal → io_resp_valid next cycle; successful store → 1 cycle after the acknowledge.
- DRAIN: io_req_ready = 0 until one io_mem_resp_valid is seen, then IDLE. No second timeout applies.
- One request in flight at a time; io_req_ready is 0 in every state except IDLE.
- io_mem_req_valid is never withdrawn before it is accepted.

Decomposition:
- Shared package contents:
  - PTE field widths and bit offsets (PPN_LSB = 10, RSW width 2, flag positions).
  - The state enumeration.
  - A pte_pack function.
- Sub-module pte_pack_unit: combinational unpacked-fields → 64-bit word, reusable by other writers.
- The FSM and timeout counter stay in pte_ad_writer.

Test Plan:
- Request addr = 0x80001000, ppn = 0x12345, v = r = w = 1, a = d = 0, set_d = 1; mem ready immediately, acknowledge 3 cycles later → one store, data = 0x48D14C7, resp d = a = 1, skipped = 0, error = 0.
- Same PTE with a = d = 1, set_d = 1 → no io_mem_req_valid; resp next cycle with skipped = 1.
- Illegal requests, each → resp error = 1, no store:
  - v = 0;
  - r = w = x = 0;
  - set_d = 1 with w = 0, r = 1.
- io_mem_req_ready low for 5 cycles and io_resp_ready low for 4 cycles → addr/data and resp payload stable throughout, exactly one store.
- TIMEOUT_CYCLES = 8, no acknowledge → error response at cycle 8 of WAIT; io_req_ready stays 0 until the acknowledge arrives 20 cycles later, then returns to 1.
- Assert reset during WAIT, then inject io_mem_resp_valid in IDLE → all outputs at reset values, no response, the next request completes normally.
